// File: rtl/charging_out_if.sv
// -----------------------------------------------------------------------------
// charging_out_if
//   Result stream from the charging stage to its downstream consumers.
//
//   Handshake: a result moves when out_vld and out_rdy are both 1 at a rising
//   clock edge. The producer holds all payload fields stable while out_vld is
//   1 and out_rdy is 0. The consumer may raise or lower out_rdy regardless of
//   out_vld, and the producer must not wait for out_rdy before asserting
//   out_vld.
//
//   Signals:
//     out_pkt_id      96  packet identifier
//     out_pkt_len     16  packet length in bytes
//     out_cnt_policy   3  one-hot policy (bit0 forward, bit1 sendtohost, bit2 drop)
//     out_cnt_report  22  counter report value
//     out_ul           1  uplink flag
//     out_cnt_en       1  1 = charged packet, 0 = uncharged bypass
//     out_vld          1  result valid (producer)
//     out_rdy          1  consumer can accept (consumer)
// -----------------------------------------------------------------------------
interface charging_out_if;
    logic [95:0] out_pkt_id;
    logic [15:0] out_pkt_len;
    logic [2:0]  out_cnt_policy;
    logic [21:0] out_cnt_report;
    logic        out_ul;
    logic        out_cnt_en;
    logic        out_vld;
    logic        out_rdy;

    modport master (
        output out_pkt_id, out_pkt_len, out_cnt_policy, out_cnt_report,
               out_ul, out_cnt_en, out_vld,
        input  out_rdy
    );

    modport slave (
        input  out_pkt_id, out_pkt_len, out_cnt_policy, out_cnt_report,
               out_ul, out_cnt_en, out_vld,
        output out_rdy
    );
endinterface

// File: rtl/charging_out_stats.sv
// -----------------------------------------------------------------------------
// charging_out_stats
//   Sink stage behind the charging block. Accepts every result on the
//   charging_out_if stream, classifies it by enforced policy and accumulates
//   saturating per-policy packet and byte counters, a bypass counter and an
//   uplink counter. Tracks the peak number of packets seen in any completed
//   window of WINDOW_CYCLES cycles and pulses on legal / illegal policies.
//
//   Ports:
//     asclk, aresetn         clock, asynchronous active-low reset
//     out_if (slave)         result stream, out_rdy driven here
//     clear_req              one-cycle pulse: zero all statistics
//     *_counting             packets per policy / bypass
//     *_capacity             byte sums per policy
//     ul_count               charged uplink packets
//     pkt_per_sec_max        largest completed-window packet count
//     check_policy           pulse per charged packet with a legal policy
//     check_false_policy     pulse per charged packet with an illegal policy
//     last_pkt_id            id of the most recently accepted packet
//     dbg_state              current FSM state (0 CLEAR, 1 RUN)
// -----------------------------------------------------------------------------
module charging_out_stats #(
    parameter int unsigned WINDOW_CYCLES = 100000000,
    parameter int unsigned RATE_W        = 29,
    parameter int unsigned CNT_W         = 48
) (
    input  logic              asclk,
    input  logic              aresetn,
    charging_out_if.slave     out_if,
    input  logic              clear_req,
    output logic [CNT_W-1:0]  forward_counting,
    output logic [CNT_W-1:0]  sendtohost_counting,
    output logic [CNT_W-1:0]  drop_counting,
    output logic [CNT_W-1:0]  forward_capacity,
    output logic [CNT_W-1:0]  sendtohost_capacity,
    output logic [CNT_W-1:0]  drop_capacity,
    output logic [CNT_W-1:0]  bypass_counting,
    output logic [CNT_W-1:0]  ul_count,
    output logic [RATE_W-1:0] pkt_per_sec_max,
    output logic              check_policy,
    output logic              check_false_policy,
    output logic [95:0]       last_pkt_id,
    output logic [0:0]        dbg_state
);

    typedef enum logic [0:0] {
        ST_CLEAR = 1'b0,
        ST_RUN   = 1'b1
    } state_e;

    state_e state;
    state_e next_state;

    // Goes high on the first edge after reset release; holds the FSM in
    // CLEAR for that edge so out_rdy first rises on the second edge.
    logic rel_q;

    logic [31:0]       win_cyc;
    logic [RATE_W-1:0] win_pkts;

    logic xfer;
    logic clear_stats;
    logic policy_legal;
    logic win_end;
    logic unused_report;

    assign xfer          = out_if.out_vld && out_if.out_rdy;
    assign policy_legal  = (out_if.out_cnt_policy == 3'b001) ||
                           (out_if.out_cnt_policy == 3'b010) ||
                           (out_if.out_cnt_policy == 3'b100);
    // A transfer coinciding with clear_req is accepted but has no effect.
    assign clear_stats   = (state == ST_CLEAR) || clear_req;
    assign win_end       = (win_cyc == 32'(WINDOW_CYCLES - 1));
    assign unused_report = ^out_if.out_cnt_report;
    assign dbg_state     = state;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] v,
                                                 input logic [15:0]      len);
        logic [CNT_W:0] sum;
        sum = {1'b0, v} + (CNT_W + 1)'(len);
        return sum[CNT_W] ? {CNT_W{1'b1}} : sum[CNT_W-1:0];
    endfunction

    // Window packet count including a transfer on the current cycle,
    // saturating at the counter width.
    logic [RATE_W:0]   win_sum;
    logic [RATE_W-1:0] win_next;
    always_comb begin
        win_sum  = {1'b0, win_pkts} + (RATE_W + 1)'(xfer);
        win_next = win_sum[RATE_W] ? {RATE_W{1'b1}} : win_sum[RATE_W-1:0];
    end

    // ---------------- FSM ----------------
    always_comb begin
        next_state = state;
        case (state)
            ST_CLEAR: if (rel_q) next_state = ST_RUN;
            ST_RUN:   if (clear_req) next_state = ST_CLEAR;
            default:  next_state = ST_CLEAR;
        endcase
    end

    always_ff @(posedge asclk or negedge aresetn) begin
        if (!aresetn) begin
            state          <= ST_CLEAR;
            rel_q          <= 1'b0;
            out_if.out_rdy <= 1'b0;
        end else begin
            state          <= next_state;
            rel_q          <= 1'b1;
            out_if.out_rdy <= (next_state == ST_RUN);
        end
    end

    // ---------------- accounting ----------------
    always_ff @(posedge asclk or negedge aresetn) begin
        if (!aresetn) begin
            forward_counting    <= '0;
            sendtohost_counting <= '0;
            drop_counting       <= '0;
            forward_capacity    <= '0;
            sendtohost_capacity <= '0;
            drop_capacity       <= '0;
            bypass_counting     <= '0;
            ul_count            <= '0;
            pkt_per_sec_max     <= '0;
            check_policy        <= 1'b0;
            check_false_policy  <= 1'b0;
            last_pkt_id         <= '0;
            win_cyc             <= '0;
            win_pkts            <= '0;
        end else if (clear_stats) begin
            forward_counting    <= '0;
            sendtohost_counting <= '0;
            drop_counting       <= '0;
            forward_capacity    <= '0;
            sendtohost_capacity <= '0;
            drop_capacity       <= '0;
            bypass_counting     <= '0;
            ul_count            <= '0;
            pkt_per_sec_max     <= '0;
            check_policy        <= 1'b0;
            check_false_policy  <= 1'b0;
            last_pkt_id         <= '0;
            win_cyc             <= '0;
            win_pkts            <= '0;
        end else begin
            check_policy       <= 1'b0;
            check_false_policy <= 1'b0;

            if (xfer) begin
                last_pkt_id <= out_if.out_pkt_id;
                if (!out_if.out_cnt_en) begin
                    bypass_counting <= sat_inc(bypass_counting);
                end else begin
                    if (out_if.out_ul) ul_count <= sat_inc(ul_count);
                    if (policy_legal) begin
                        check_policy <= 1'b1;
                        case (out_if.out_cnt_policy)
                            3'b001: begin
                                forward_counting <= sat_inc(forward_counting);
                                forward_capacity <= sat_add(forward_capacity, out_if.out_pkt_len);
                            end
                            3'b010: begin
                                sendtohost_counting <= sat_inc(sendtohost_counting);
                                sendtohost_capacity <= sat_add(sendtohost_capacity, out_if.out_pkt_len);
                            end
                            default: begin
                                drop_counting <= sat_inc(drop_counting);
                                drop_capacity <= sat_add(drop_capacity, out_if.out_pkt_len);
                            end
                        endcase
                    end else begin
                        check_false_policy <= 1'b1;
                    end
                end
            end

            // A transfer on the last cycle of a window counts toward that window.
            if (win_end) begin
                if (win_next > pkt_per_sec_max) pkt_per_sec_max <= win_next;
                win_pkts <= '0;
                win_cyc  <= '0;
            end else begin
                win_pkts <= win_next;
                win_cyc  <= win_cyc + 32'd1;
            end
        end
    end

endmodule

// File: tb/tb_charging_out_stats.sv
module tb_charging_out_stats;

  localparam int unsigned W = 16;
  localparam longint unsigned MAX48 = 64'hFFFF_FFFF_FFFF;
  localparam longint unsigned MAXR  = (64'd1 << 29) - 1;

  logic clk;
  logic aresetn;
  logic clear_req;
  logic [47:0] forward_counting, sendtohost_counting, drop_counting;
  logic [47:0] forward_capacity, sendtohost_capacity, drop_capacity;
  logic [47:0] bypass_counting, ul_count;
  logic [28:0] pkt_per_sec_max;
  logic check_policy, check_false_policy;
  logic [95:0] last_pkt_id;
  logic [0:0] dbg_state;

  charging_out_if bus();

  charging_out_stats #(.WINDOW_CYCLES(W), .RATE_W(29), .CNT_W(48)) dut (
    .asclk(clk),
    .aresetn(aresetn),
    .out_if(bus),
    .clear_req(clear_req),
    .forward_counting(forward_counting),
    .sendtohost_counting(sendtohost_counting),
    .drop_counting(drop_counting),
    .forward_capacity(forward_capacity),
    .sendtohost_capacity(sendtohost_capacity),
    .drop_capacity(drop_capacity),
    .bypass_counting(bypass_counting),
    .ul_count(ul_count),
    .pkt_per_sec_max(pkt_per_sec_max),
    .check_policy(check_policy),
    .check_false_policy(check_false_policy),
    .last_pkt_id(last_pkt_id),
    .dbg_state(dbg_state)
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- bookkeeping ----------------
  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [95:0] id;
    logic [47:0] fc, sc, dc, fcap, scap, dcap, byp, ulc;
    logic [28:0] mx;
    logic        cp, cfp;
  } rec_t;

  rec_t exp_q[$];

  task automatic chk(input string name, input logic [95:0] act, input logic [95:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // ---------------- reference model ----------------
  // Statistics indexed by policy position (0 forward, 1 sendtohost, 2 drop).
  longint unsigned m_cnt[3];
  longint unsigned m_cap[3];
  longint unsigned m_byp, m_ulc, m_win, m_max;
  int unsigned     m_cyc;
  bit              m_rdy;
  int              m_hold;
  logic [95:0]     next_id;

  function automatic longint unsigned sat(input longint unsigned v, input longint unsigned lim);
    return (v > lim) ? lim : v;
  endfunction

  task automatic model_zero();
    for (int i = 0; i < 3; i++) begin
      m_cnt[i] = 0;
      m_cap[i] = 0;
    end
    m_byp = 0; m_ulc = 0; m_win = 0; m_max = 0; m_cyc = 0;
  endtask

  // One clock cycle: present inputs at the negedge, predict the edge, advance.
  task automatic drive(input bit vld, input bit [2:0] pol, input bit [15:0] len,
                       input bit en, input bit ul, input bit clr);
    bit   xfer;
    bit   cp, cfp;
    int   idx;
    rec_t r;
    bus.out_vld        = vld;
    bus.out_cnt_policy = pol;
    bus.out_pkt_len    = len;
    bus.out_cnt_en     = en;
    bus.out_ul         = ul;
    bus.out_cnt_report = 22'($urandom);
    clear_req          = clr;
    if (vld) begin
      next_id = next_id + 96'd1;
      bus.out_pkt_id = next_id;
    end
    chk("out_rdy", {95'd0, bus.out_rdy}, {95'd0, m_rdy});
    xfer = vld && m_rdy;
    cp = 1'b0;
    cfp = 1'b0;
    if (m_rdy) begin
      if (clr) begin
        model_zero();
        m_rdy  = 1'b0;
        m_hold = 1;
      end else begin
        if (xfer) begin
          if (!en) begin
            m_byp = sat(m_byp + 1, MAX48);
          end else begin
            if (ul) m_ulc = sat(m_ulc + 1, MAX48);
            if ($countones(pol) == 1) begin
              idx = (pol == 3'b001) ? 0 : (pol == 3'b010) ? 1 : 2;
              m_cnt[idx] = sat(m_cnt[idx] + 1, MAX48);
              m_cap[idx] = sat(m_cap[idx] + longint'(len), MAX48);
              cp = 1'b1;
            end else begin
              cfp = 1'b1;
            end
          end
        end
        m_win = sat(m_win + (xfer ? 1 : 0), MAXR);
        if (m_cyc == W - 1) begin
          if (m_win > m_max) m_max = m_win;
          m_win = 0;
          m_cyc = 0;
        end else begin
          m_cyc++;
        end
        if (xfer) begin
          r.id = bus.out_pkt_id;
          r.fc = 48'(m_cnt[0]); r.sc = 48'(m_cnt[1]); r.dc = 48'(m_cnt[2]);
          r.fcap = 48'(m_cap[0]); r.scap = 48'(m_cap[1]); r.dcap = 48'(m_cap[2]);
          r.byp = 48'(m_byp); r.ulc = 48'(m_ulc);
          r.mx = 29'(m_max);
          r.cp = cp; r.cfp = cfp;
          exp_q.push_back(r);
        end
      end
    end else if (m_hold > 0) begin
      m_hold--;
      if (m_hold == 0) m_rdy = 1'b1;
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 3'b000, 16'd0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_fwd_cnt"},  {48'd0, forward_counting},    96'd0);
    chk({tag, "_sth_cnt"},  {48'd0, sendtohost_counting}, 96'd0);
    chk({tag, "_drp_cnt"},  {48'd0, drop_counting},       96'd0);
    chk({tag, "_fwd_cap"},  {48'd0, forward_capacity},    96'd0);
    chk({tag, "_sth_cap"},  {48'd0, sendtohost_capacity}, 96'd0);
    chk({tag, "_drp_cap"},  {48'd0, drop_capacity},       96'd0);
    chk({tag, "_bypass"},   {48'd0, bypass_counting},     96'd0);
    chk({tag, "_ul"},       {48'd0, ul_count},            96'd0);
    chk({tag, "_max"},      {67'd0, pkt_per_sec_max},     96'd0);
    chk({tag, "_last_id"},  last_pkt_id,                  96'd0);
  endtask

  // ---------------- monitor / scoreboard ----------------
  logic [95:0] seen_id = '0;
  rec_t        got;

  always @(posedge clk) begin
    #1;
    if (aresetn) begin
      if (last_pkt_id !== seen_id) begin
        seen_id = last_pkt_id;
        if (last_pkt_id != 96'd0) begin
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_result actual=%0h required=none", last_pkt_id);
          end else begin
            got = exp_q.pop_front();
            chk("last_pkt_id", last_pkt_id, got.id);
            chk("forward_counting", {48'd0, forward_counting}, {48'd0, got.fc});
            chk("sendtohost_counting", {48'd0, sendtohost_counting}, {48'd0, got.sc});
            chk("drop_counting", {48'd0, drop_counting}, {48'd0, got.dc});
            chk("forward_capacity", {48'd0, forward_capacity}, {48'd0, got.fcap});
            chk("sendtohost_capacity", {48'd0, sendtohost_capacity}, {48'd0, got.scap});
            chk("drop_capacity", {48'd0, drop_capacity}, {48'd0, got.dcap});
            chk("bypass_counting", {48'd0, bypass_counting}, {48'd0, got.byp});
            chk("ul_count", {48'd0, ul_count}, {48'd0, got.ulc});
            chk("pkt_per_sec_max", {67'd0, pkt_per_sec_max}, {67'd0, got.mx});
            chk("check_policy", {95'd0, check_policy}, {95'd0, got.cp});
            chk("check_false_policy", {95'd0, check_false_policy}, {95'd0, got.cfp});
          end
        end
      end else begin
        chk("idle_pulses", {94'd0, check_policy, check_false_policy}, 96'd0);
      end
    end
  end

  // ---------------- watchdog ----------------
  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  // ---------------- stimulus ----------------
  initial begin
    bit [2:0] pol;
    next_id = {32'hA5A5_0000, 64'd0};
    model_zero();
    m_rdy  = 1'b0;
    m_hold = 2;

    // Reset with out_vld held high.
    aresetn            = 1'b0;
    clear_req          = 1'b0;
    bus.out_vld        = 1'b1;
    bus.out_pkt_id     = 96'd7;
    bus.out_pkt_len    = 16'd64;
    bus.out_cnt_policy = 3'b001;
    bus.out_cnt_report = 22'd0;
    bus.out_ul         = 1'b0;
    bus.out_cnt_en     = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    aresetn = 1'b1;
    chk("reset_rdy", {95'd0, bus.out_rdy}, 96'd0);
    chk_all_zero("reset");

    // Held valid: ready 0 after first edge, 1 after second; then three legal
    // policies.
    drive(1'b1, 3'b001, 16'd64, 1'b1, 1'b0, 1'b0);
    drive(1'b1, 3'b001, 16'd64, 1'b1, 1'b0, 1'b0);
    chk_all_zero("pre_xfer");
    drive(1'b1, 3'b001, 16'd64,   1'b1, 1'b1, 1'b0);
    drive(1'b1, 3'b010, 16'd1500, 1'b1, 1'b0, 1'b0);
    drive(1'b1, 3'b100, 16'd40,   1'b1, 1'b1, 1'b0);

    // Illegal policies and a bypass packet.
    drive(1'b1, 3'b011, 16'd100, 1'b1, 1'b0, 1'b0);
    drive(1'b1, 3'b000, 16'd200, 1'b1, 1'b1, 1'b0);
    drive(1'b1, 3'b001, 16'd300, 1'b0, 1'b1, 1'b0);
    idle(2);
    chk("fwd_cap_after_legal", {48'd0, forward_capacity}, 96'd64);
    chk("bypass_after_illegal", {48'd0, bypass_counting}, 96'd1);

    // clear_req together with a transfer.
    drive(1'b1, 3'b001, 16'd77, 1'b1, 1'b1, 1'b1);
    drive(1'b0, 3'b000, 16'd0, 1'b0, 1'b0, 1'b0);
    chk_all_zero("clear");

    // Window 1: five transfers on cycles 11..15; window 2: two transfers.
    for (int c = 0; c < W; c++)
      drive(c >= 11, 3'b010, 16'(c * 10 + 1), 1'b1, 1'b0, 1'b0);
    chk("max_win1", {67'd0, pkt_per_sec_max}, 96'd5);
    for (int c = 0; c < W; c++)
      drive(c == 3 || c == 9, 3'b100, 16'd55, 1'b1, 1'b0, 1'b0);
    chk("max_win2", {67'd0, pkt_per_sec_max}, 96'd5);

    // Saturating capacity.
    force dut.forward_capacity = 48'hFFFF_FFFF_FFF6;
    #1;
    release dut.forward_capacity;
    m_cap[0] = 64'hFFFF_FFFF_FFF6;
    drive(1'b1, 3'b001, 16'd100, 1'b1, 1'b0, 1'b0);
    chk("fwd_cap_sat", {48'd0, forward_capacity}, {48'd0, 48'hFFFF_FFFF_FFFF});

    // Randomized traffic.
    for (int i = 0; i < 400; i++) begin
      case ($urandom_range(0, 3))
        0:       pol = 3'($urandom_range(0, 7));
        1:       pol = 3'b001;
        2:       pol = 3'b010;
        default: pol = 3'b100;
      endcase
      drive($urandom_range(0, 3) != 0, pol, 16'($urandom),
            $urandom_range(0, 5) != 0, 1'($urandom_range(0, 1)),
            $urandom_range(0, 99) == 0);
    end
    idle(3);
    chk("queue_drained", 96'(exp_q.size()), 96'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
